// File: rtl/conv_pkg.sv
// conv_pkg
// Shared definitions for the convolution sequencer and conv_blk:
//   - seq_state_t     : sequencer FSM state encoding
//   - FM_WIDTH, W_WIDTH, ACC_WIDTH : default datapath widths
//   - calc_out_size() : output feature-map side length for a given geometry
//   - addr_bits()     : address width needed to index 'depth' words (min 1)
package conv_pkg;

    localparam int FM_WIDTH  = 30;
    localparam int W_WIDTH   = 18;
    localparam int ACC_WIDTH = 48;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    function automatic int calc_out_size(input int fm_size, input int kernel_size,
                                         input int padding, input int stride);
        return ((fm_size - kernel_size + 2 * padding) / stride) + 1;
    endfunction

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_seq_addr_gen.sv
// conv_seq_addr_gen
// Up-counter with clear, enable and terminal-count flag. Counting stops at
// TERMINAL (never wraps); i_clr returns it to zero.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-low reset
//   i_clr   synchronous clear to 0 (wins over i_en)
//   i_en    count enable
//   o_cnt   current count
//   o_tc    high while o_cnt == TERMINAL
module conv_seq_addr_gen #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_reg <= '0;
        end else if (i_clr) begin
            cnt_reg <= '0;
        end else if (i_en && (cnt_reg != TC_VAL)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign o_cnt = cnt_reg;
    assign o_tc  = (cnt_reg == TC_VAL);

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl
// Sequences one conv_blk pass: reads K*K weights from the weight BRAM into
// conv_blk, streams the FM BRAM into conv_blk, and writes every conv_blk
// result to the out-FM BRAM. One pass per accepted i_start.
// Optional build macro: CONV_SEQ_CTRL_PERF_EN adds o_cycle_cnt (busy cycles
// of the last/current pass, saturating at 2^32-1).
// Ports:
//   i_clk, i_rst (sync, active-low)
//   i_start        start pulse, sampled in IDLE only
//   o_busy/o_done  pass in progress / one-cycle end-of-pass pulse
//   o_err          sticky: result seen outside the capture window or overflow
//   o_w_addr,  i_w_rdata   weight BRAM (1-cycle read latency)
//   o_fm_addr, i_fm_rdata  FM BRAM (1-cycle read latency)
//   o_weight_data, o_fm_data, o_go          to conv_blk
//   i_conv_en, i_conv_result                from conv_blk
//   o_wr_en, o_wr_addr, o_wr_data           out-FM BRAM write port
//   o_cycle_cnt    (CONV_SEQ_CTRL_PERF_EN only)
module conv_seq_ctrl #(
    parameter int KERNEL_SIZE = 3,
    parameter int FM_SIZE     = 252,
    parameter int PADDING     = 0,
    parameter int STRIDE      = 1,
    parameter int FM_WIDTH    = conv_pkg::FM_WIDTH,
    parameter int W_WIDTH     = conv_pkg::W_WIDTH,
    parameter int ACC_WIDTH   = conv_pkg::ACC_WIDTH,
    localparam int OUT_SIZE   = conv_pkg::calc_out_size(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE),
    localparam int W_AW       = conv_pkg::addr_bits(KERNEL_SIZE * KERNEL_SIZE),
    localparam int FM_AW      = conv_pkg::addr_bits(FM_SIZE * FM_SIZE),
    localparam int WR_AW      = conv_pkg::addr_bits(OUT_SIZE * OUT_SIZE)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_err,
    output logic [W_AW-1:0]             o_w_addr,
    input  logic [W_WIDTH-1:0]          i_w_rdata,
    output logic [FM_AW-1:0]            o_fm_addr,
    input  logic [FM_WIDTH-1:0]         i_fm_rdata,
    output logic [W_WIDTH-1:0]          o_weight_data,
    output logic [FM_WIDTH-1:0]         o_fm_data,
    output logic                        o_go,
    input  logic                        i_conv_en,
    input  logic signed [ACC_WIDTH-1:0] i_conv_result,
    output logic                        o_wr_en,
    output logic [WR_AW-1:0]            o_wr_addr,
    output logic [ACC_WIDTH-1:0]        o_wr_data
`ifdef CONV_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]                 o_cycle_cnt
`endif
);

    import conv_pkg::*;

    localparam int W_LAST    = KERNEL_SIZE * KERNEL_SIZE - 1;
    localparam int FM_LAST   = FM_SIZE * FM_SIZE - 1;
    localparam int RES_TOTAL = OUT_SIZE * OUT_SIZE;
    localparam int RC_W      = $clog2(RES_TOTAL + 1);

    seq_state_t state_reg, state_next;

    logic                 start_acc;
    logic                 w_tc, fm_tc, rc_tc;
    logic [RC_W-1:0]      rc_cnt;
    logic                 capture_win;
    logic                 res_accept;
    logic                 res_reject;

    logic [W_WIDTH-1:0]   weight_reg;
    logic [FM_WIDTH-1:0]  fm_reg;
    logic                 stream_d1_reg;
    logic                 go_reg;
    logic                 wr_en_reg;
    logic [WR_AW-1:0]     wr_addr_reg;
    logic [ACC_WIDTH-1:0] wr_data_reg;
    logic                 err_reg;

    assign start_acc   = (state_reg == ST_IDLE) && i_start;
    assign capture_win = (state_reg == ST_STREAM) || (state_reg == ST_DRAIN);
    // Results are only taken inside the capture window and until the
    // expected count is reached; anything else is flagged, never written.
    assign res_accept  = i_conv_en && capture_win && !rc_tc;
    assign res_reject  = i_conv_en && !res_accept;

    conv_seq_addr_gen #(.WIDTH(W_AW), .TERMINAL(W_LAST)) u_w_addr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (start_acc),
        .i_en  (state_reg == ST_LOAD_W),
        .o_cnt (o_w_addr),
        .o_tc  (w_tc)
    );

    conv_seq_addr_gen #(.WIDTH(FM_AW), .TERMINAL(FM_LAST)) u_fm_addr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (start_acc),
        .i_en  (state_reg == ST_STREAM),
        .o_cnt (o_fm_addr),
        .o_tc  (fm_tc)
    );

    conv_seq_addr_gen #(.WIDTH(RC_W), .TERMINAL(RES_TOTAL)) u_res_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (start_acc),
        .i_en  (res_accept),
        .o_cnt (rc_cnt),
        .o_tc  (rc_tc)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (i_start) state_next = ST_LOAD_W;
            ST_LOAD_W: if (w_tc)    state_next = ST_STREAM;
            ST_STREAM: if (fm_tc)   state_next = ST_DRAIN;
            ST_DRAIN:  if (rc_tc)   state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_reg     <= ST_IDLE;
            weight_reg    <= '0;
            fm_reg        <= '0;
            stream_d1_reg <= 1'b0;
            go_reg        <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            weight_reg    <= i_w_rdata;
            fm_reg        <= i_fm_rdata;
            // An FM address issued in cycle c is on i_fm_rdata in c+1 and on
            // o_fm_data in c+2; go follows the same two-stage delay so it
            // rises together with pixel 0.
            stream_d1_reg <= (state_reg == ST_STREAM);
            if ((state_next == ST_DONE) || (state_next == ST_IDLE)) begin
                go_reg <= 1'b0;
            end else if (stream_d1_reg) begin
                go_reg <= 1'b1;
            end
            wr_en_reg <= res_accept;
            if (res_accept) begin
                wr_addr_reg <= rc_cnt[WR_AW-1:0];
                wr_data_reg <= i_conv_result;
            end
            if (res_reject) begin
                err_reg <= 1'b1;
            end else if (start_acc) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign o_busy        = (state_reg != ST_IDLE);
    assign o_done        = (state_reg == ST_DONE);
    assign o_err         = err_reg;
    assign o_weight_data = weight_reg;
    assign o_fm_data     = fm_reg;
    assign o_go          = go_reg;
    assign o_wr_en       = wr_en_reg;
    assign o_wr_addr     = wr_addr_reg;
    assign o_wr_data     = wr_data_reg;

`ifdef CONV_SEQ_CTRL_PERF_EN
    logic [31:0] cycle_cnt_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cycle_cnt_reg <= '0;
        end else if (start_acc) begin
            cycle_cnt_reg <= '0;
        end else if ((state_reg != ST_IDLE) && (cycle_cnt_reg != 32'hFFFF_FFFF)) begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
        end
    end

    assign o_cycle_cnt = cycle_cnt_reg;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;

    localparam int K      = 3;
    localparam int FMS    = 5;
    localparam int OUTS   = 3;
    localparam int NRES   = OUTS * OUTS;
    localparam int W_AW   = 4;
    localparam int FM_AW  = 5;
    localparam int WR_AW  = 4;
    localparam int FM_W   = 30;
    localparam int W_W    = 18;
    localparam int ACC_W  = 48;

    typedef struct {
        logic [WR_AW-1:0] addr;
        logic [ACC_W-1:0] data;
    } wr_item_t;

    logic                    i_clk = 1'b0;
    logic                    i_rst = 1'b0;
    logic                    i_start = 1'b0;
    logic                    o_busy, o_done, o_err, o_go, o_wr_en;
    logic [W_AW-1:0]         o_w_addr;
    logic [W_W-1:0]          i_w_rdata = '0;
    logic [FM_AW-1:0]        o_fm_addr;
    logic [FM_W-1:0]         i_fm_rdata = '0;
    logic [W_W-1:0]          o_weight_data;
    logic [FM_W-1:0]         o_fm_data;
    logic                    i_conv_en = 1'b0;
    logic signed [ACC_W-1:0] i_conv_result = '0;
    logic [WR_AW-1:0]        o_wr_addr;
    logic [ACC_W-1:0]        o_wr_data;
`ifdef CONV_SEQ_CTRL_PERF_EN
    logic [31:0]             o_cycle_cnt;
`endif

    logic [W_W-1:0]   wmem   [K*K];
    logic [FM_W-1:0]  fmmem  [FMS*FMS];
    logic [ACC_W-1:0] outmem [NRES];

    wr_item_t exp_q[$];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int busy_cycles = 0;

    always #5 i_clk = ~i_clk;

    conv_seq_ctrl #(.KERNEL_SIZE(K), .FM_SIZE(FMS), .PADDING(0), .STRIDE(1),
                    .FM_WIDTH(FM_W), .W_WIDTH(W_W), .ACC_WIDTH(ACC_W)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_w_addr      (o_w_addr),
        .i_w_rdata     (i_w_rdata),
        .o_fm_addr     (o_fm_addr),
        .i_fm_rdata    (i_fm_rdata),
        .o_weight_data (o_weight_data),
        .o_fm_data     (o_fm_data),
        .o_go          (o_go),
        .i_conv_en     (i_conv_en),
        .i_conv_result (i_conv_result),
        .o_wr_en       (o_wr_en),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data)
`ifdef CONV_SEQ_CTRL_PERF_EN
        ,
        .o_cycle_cnt   (o_cycle_cnt)
`endif
    );

    // BRAM models: 1-cycle registered read, synchronous write.
    always @(posedge i_clk) begin
        i_w_rdata  <= wmem[o_w_addr];
        i_fm_rdata <= fmmem[o_fm_addr];
        if (o_wr_en) outmem[o_wr_addr] <= o_wr_data;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Write-port scoreboard and event counters.
    always @(negedge i_clk) begin
        if (o_wr_en) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexp_en", 64'(o_wr_en), 64'd0);
            end else begin
                wr_item_t it;
                it = exp_q.pop_front();
                $display("wr addr=%0d data=%0d exp_addr=%0d exp_data=%0d",
                         o_wr_addr, o_wr_data, it.addr, it.data);
                chk("wr_addr", 64'(o_wr_addr), 64'(it.addr));
                chk("wr_data", 64'(o_wr_data), 64'(it.data));
            end
        end
        if (o_done) done_cnt++;
        if (o_busy) busy_cycles++;
    end

    task automatic emit(input int value, input bit expect_wr, input int idx);
        wr_item_t it;
        i_conv_en     = 1'b1;
        i_conv_result = ACC_W'(value);
        if (expect_wr) begin
            it.addr = WR_AW'(idx);
            it.data = ACC_W'(value);
            exp_q.push_back(it);
        end
        @(negedge i_clk);
        i_conv_en = 1'b0;
    endtask

    task automatic run_pass(input int base, input int delay, input int gap,
                            input bit chk_w, input bit bad_loadw, input bit extra,
                            input bit chk_clr, input bit hold, input bit exp_err);
        int d0;
        bit seen;
        d0 = done_cnt;
        i_start = 1'b1;
        busy_cycles = 0;
        @(negedge i_clk);
        if (!hold) i_start = 1'b0;
        if (chk_clr) chk("err_cleared_on_start", 64'(o_err), 64'd0);
        if (chk_w) begin
            // Addresses 0..8 on consecutive cycles, data 1..9 two cycles later.
            for (int i = 0; i < K*K + 2; i++) begin
                if (i < K*K) chk($sformatf("w_addr%0d", i), 64'(o_w_addr), 64'(i));
                if (i >= 2) chk($sformatf("w_data%0d", i-2), 64'(o_weight_data), 64'(i-1));
                @(negedge i_clk);
            end
        end
        if (bad_loadw) begin
            emit(999, 1'b0, 0);
            chk("err_after_loadw_result", 64'(o_err), 64'd1);
            chk("no_wr_in_loadw", 64'(o_wr_en), 64'd0);
        end
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (o_go) begin seen = 1'b1; break; end
            @(negedge i_clk);
        end
        chk("go_seen", 64'(seen), 64'd1);
        repeat (delay) @(negedge i_clk);
        for (int n = 0; n < NRES; n++) begin
            emit(base + n, 1'b1, n);
            repeat (gap - 1) @(negedge i_clk);
        end
        if (extra) begin
            emit(base + NRES, 1'b0, 0);
            chk("err_after_extra_result", 64'(o_err), 64'd1);
        end
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (o_done) begin seen = 1'b1; break; end
            @(negedge i_clk);
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("go_low_in_done", 64'(o_go), 64'd0);
        @(negedge i_clk);
        chk("idle_after_done", 64'(o_busy), 64'd0);
        if (hold) begin
            @(negedge i_clk);
            chk("held_start_restart", 64'(o_busy), 64'd1);
            chk("held_start_w_addr0", 64'(o_w_addr), 64'd0);
            i_start = 1'b0;
        end else begin
            chk("done_once", 64'(done_cnt - d0), 64'd1);
`ifdef CONV_SEQ_CTRL_PERF_EN
            chk("cycle_cnt", 64'(o_cycle_cnt), 64'(busy_cycles));
`endif
            @(negedge i_clk);
        end
        chk("err_end", 64'(o_err), 64'(exp_err));
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        for (int n = 0; n < NRES; n++)
            chk($sformatf("outmem%0d", n), 64'(outmem[n]), 64'(base + n));
    endtask

    initial begin
        bit seen;
        int d0;
        for (int i = 0; i < K*K; i++) wmem[i] = W_W'(i + 1);
        for (int i = 0; i < FMS*FMS; i++) fmmem[i] = FM_W'(1000 + i);
        for (int i = 0; i < NRES; i++) outmem[i] = '0;

        repeat (3) @(negedge i_clk);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_go", 64'(o_go), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_wr_en", 64'(o_wr_en), 64'd0);
        chk("rst_w_addr", 64'(o_w_addr), 64'd0);
        chk("rst_fm_addr", 64'(o_fm_addr), 64'd0);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);

        // base, delay, gap, chk_w, bad_loadw, extra, chk_clr, hold, exp_err
        run_pass(100, 2, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // back-to-back results
        run_pass(300, 18, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // results run into DRAIN
        run_pass(400, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);  // result during LOAD_W
        run_pass(500, 1, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);  // 10th result
        run_pass(600, 3, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);  // i_start held high

        // The held start launched a second pass; abort it mid-STREAM.
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (o_busy && o_fm_addr == FM_AW'(12)) begin seen = 1'b1; break; end
            @(negedge i_clk);
        end
        chk("fm12_seen", 64'(seen), 64'd1);
        d0 = done_cnt;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("midrst_busy", 64'(o_busy), 64'd0);
        chk("midrst_go", 64'(o_go), 64'd0);
        chk("midrst_wr_en", 64'(o_wr_en), 64'd0);
        chk("midrst_fm_addr", 64'(o_fm_addr), 64'd0);
        i_rst = 1'b1;
        repeat (40) @(negedge i_clk);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("midrst_stays_idle", 64'(o_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
